audio_echo_suppressor: RTL
==========================

# audio_echo_suppressor

Multi-channel, parametrised feedback echo suppressor for the audio path. Each channel's output is its input minus an attenuated copy of that channel's own output from a run-time-selectable number of samples earlier, saturated to full scale. It sits between the I2S receive deserialiser and the time/frequency processing chain, and accepts channel-interleaved samples through a valid strobe. It replaces the fixed single-channel FIFO-based echo stage with per-channel circular delay lines, priming control, a programmable attenuation shift and a bypass mode.

## Interface

- DATA_WIDTH, 16, sample width, two's complement
- DELAY_DEPTH, 1024, delay-line depth per channel in samples; power of two, >= 4
- CHANNELS, 2, number of interleaved channels; power of two, >= 1
- AW, $clog2(DELAY_DEPTH), derived delay-address width
- CW, max(1,$clog2(CHANNELS)), derived channel-index width

- sck  in  1  processing clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  data_in/in_ch valid this cycle
- in_ch  in  CW  channel index of data_in
- data_in  in  DATA_WIDTH  signed input sample
- delay_len  in  AW  echo delay in samples; 0 and 1 are treated as 2
- gain_shift  in  4  attenuation: the echo term is the delayed output >>> gain_shift
- bypass  in  1  1 = pass data_in unchanged
- out_valid  out  1  data_out/out_ch valid
- out_ch  out  CW  channel index of data_out
- data_out  out  DATA_WIDTH  signed processed sample
- primed  out  CHANNELS  per-channel flag: delay line holds >= effective delay_len samples

## Operation

- Storage: one RAM of CHANNELS*DELAY_DEPTH words, addressed {ch, ptr}. Per channel: wr_ptr (AW bits, wraps modulo DELAY_DEPTH) and fill count (saturates at DELAY_DEPTH-1).
- Stage 1, on in_valid:
  - Register data_in, in_ch, bypass and gain_shift.
  - Compute eff_len = max(delay_len, 2).
  - Issue a RAM read at {in_ch, wr_ptr[in_ch] - eff_len} (modulo DELAY_DEPTH).
  - Register use_echo = (fill[in_ch] >= eff_len).
- Stage 2, compute:
  - echo = use_echo ? (rd_data >>> gain_shift) : 0. The shift is arithmetic.
  - diff = sext(data_in, DATA_WIDTH+1) - sext(echo, DATA_WIDTH+1).
  - Saturate diff to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
  - If bypass, the result is data_in.
- Stage 2, write-back:
  - Write the result to {ch, wr_ptr[ch]}.
  - Increment wr_ptr[ch] and fill[ch].
  - Register data_out, out_ch and out_valid=1.
  - Bypassed samples are also written, so leaving bypass is glitch-free.
- primed[c] = (fill[c] >= max(delay_len, 2)). This output is combinational from registers.
- Channels are fully independent. Samples may arrive in any channel order.
- A delay_len change takes effect on the next accepted sample. Buffer contents and fill are not cleared.
- Hazard: the minimum delay of 2 guarantees that a read never targets the word written in the same cycle, even with back-to-back same-channel samples. No forwarding path exists.

## Timing

- Reset values: out_valid=0, out_ch=0, data_out=0, primed=0; all wr_ptr and fill = 0.
- RAM contents are not cleared by reset. The fill gating masks stale data.
- Latency: out_valid rises exactly 2 sck edges after the in_valid edge.
- Throughput: one sample per cycle, no backpressure, no gaps required.
- out_valid is 0 in any cycle with no sample in stage 2. data_out holds its last value while out_valid=0.
- Reset asserted mid-stream: everything aborts immediately and in-flight samples are discarded. After release, each channel re-primes, so its first eff_len outputs equal its inputs.
- Wrap-around: wr_ptr wraps from DELAY_DEPTH-1 to 0 with no discontinuity in the echo.
- delay_len = DELAY_DEPTH-1 is legal: the echo uses the oldest stored sample.

## Test plan

Bench parameters: DATA_WIDTH=16, DELAY_DEPTH=16, CHANNELS=2.

- Reset: hold rst_n=0 with random inputs -> out_valid=0, data_out=0, primed=00. After release, the first in_valid produces out_valid exactly 2 cycles later.
- Impulse: ch0, delay_len=4, gain_shift=1, input 16384 then 15 zeros -> outputs at samples 0/4/8/12 = 16384/-8192/4096/-2048, all other samples 0; primed[0] rises after the 4th sample.
- Saturation:
  - delay_len=2, gain_shift=0, ch0 inputs -30000, 0, 30000 -> third output 32767.
  - Inputs 30000, 0, -30000 -> third output -32768.
- Channel isolation and interleave: alternate ch0 (the impulse stimulus) and ch1 (all zeros) on back-to-back cycles -> ch1 outputs are all 0; ch0 outputs match the impulse case; out_ch mirrors the input order.
- Clamp and bypass:
  - delay_len=0 gives the same results as delay_len=2.
  - bypass=1 with the impulse -> data_out equals data_in.
  - Dropping bypass after 8 samples -> the echo uses the stored bypassed values.
- Reset mid-operation and wrap-around:
  - Assert rst_n=0 mid-stream at sample 20 -> after release, the first 4 outputs (delay_len=4) equal their inputs.
  - Run 40 samples with delay_len=15 -> wrap causes no corruption against the reference model.

Source files
------------

// File: rtl/audio_echo_suppressor_if.sv
// -----------------------------------------------------------------------------
// audio_echo_suppressor_if
// Sample stream bundle for the echo suppressor.
//   in_valid / in_ch / data_in    : channel-interleaved input samples
//   out_valid / out_ch / data_out : processed samples, same channel order
// Modports:
//   master : upstream/driver side (drives in_*, observes out_*)
//   slave  : the suppressor (consumes in_*, drives out_*)
// -----------------------------------------------------------------------------
interface audio_echo_suppressor_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int CW         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
  logic                         in_valid;
  logic [CW-1:0]                in_ch;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic                         out_valid;
  logic [CW-1:0]                out_ch;
  logic signed [DATA_WIDTH-1:0] data_out;

  modport master (
    output in_valid, in_ch, data_in,
    input  out_valid, out_ch, data_out
  );

  modport slave (
    input  in_valid, in_ch, data_in,
    output out_valid, out_ch, data_out
  );
endinterface

// File: rtl/audio_echo_suppressor.sv
// -----------------------------------------------------------------------------
// audio_echo_suppressor
// Multi-channel feedback echo suppressor:
//   y[n] = sat( x[n] - (y[n - L] >>> gain_shift) ),  L = max(delay_len, 2)
// Each channel keeps its own circular delay line of past outputs inside one
// shared RAM addressed {ch, ptr}. Two-stage pipeline: stage 1 reads the
// delayed output, stage 2 subtracts, saturates, writes back and outputs.
// Ports:
//   sck        : processing clock
//   rst_n      : asynchronous active-low reset (control state only)
//   io         : sample stream (slave modport), in_* in, out_* out
//   delay_len  : echo delay in samples, 0 and 1 behave as 2
//   gain_shift : arithmetic right shift applied to the echo term
//   bypass     : 1 = output equals input (still written to the delay line)
//   primed     : per-channel, delay line holds at least L samples
// -----------------------------------------------------------------------------
module audio_echo_suppressor #(
  parameter int DATA_WIDTH  = 16,
  parameter int DELAY_DEPTH = 1024,
  parameter int CHANNELS    = 2
) (
  input  logic                      sck,
  input  logic                      rst_n,
  audio_echo_suppressor_if.slave    io,
  input  logic [$clog2(DELAY_DEPTH)-1:0] delay_len,
  input  logic [3:0]                gain_shift,
  input  logic                      bypass,
  output logic [CHANNELS-1:0]       primed
);

  localparam int AW = $clog2(DELAY_DEPTH);
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int MW = CW + AW;
  localparam logic [AW-1:0] FILL_MAX = AW'(DELAY_DEPTH - 1);
  localparam logic [AW-1:0] MIN_LEN  = AW'(2);

  // A delay shorter than 2 would read the word being written this cycle.
  function automatic logic [AW-1:0] clamp_len(input logic [AW-1:0] len);
    return (len < MIN_LEN) ? MIN_LEN : len;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [DATA_WIDTH:0] v);
    if (v[DATA_WIDTH] != v[DATA_WIDTH-1])
      return v[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}} : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    return v[DATA_WIDTH-1:0];
  endfunction

  logic signed [DATA_WIDTH-1:0] mem [CHANNELS*DELAY_DEPTH];

  logic [AW-1:0] wr_ptr_q [CHANNELS];
  logic [AW-1:0] wr_ptr_d [CHANNELS];
  logic [AW-1:0] fill_q   [CHANNELS];
  logic [AW-1:0] fill_d   [CHANNELS];

  logic                         vld_p1_q, vld_p1_d;
  logic [CW-1:0]                ch_p1_q, ch_p1_d;
  logic [AW-1:0]                wptr_p1_q, wptr_p1_d;
  logic signed [DATA_WIDTH-1:0] data_p1_q, data_p1_d;
  logic                         bypass_p1_q, bypass_p1_d;
  logic [3:0]                   shift_p1_q, shift_p1_d;
  logic                         use_echo_p1_q, use_echo_p1_d;
  logic signed [DATA_WIDTH-1:0] rd_data_p1_q;

  logic                         out_valid_q, out_valid_d;
  logic [CW-1:0]                out_ch_q, out_ch_d;
  logic signed [DATA_WIDTH-1:0] data_out_q, data_out_d;

  logic                         pending;
  logic [AW-1:0]                eff_len;
  logic [AW-1:0]                cur_ptr;
  logic [AW-1:0]                cur_fill;
  logic [MW-1:0]                rd_addr;
  logic signed [DATA_WIDTH-1:0] echo;
  logic signed [DATA_WIDTH:0]   diff;
  logic signed [DATA_WIDTH-1:0] result;

  always_comb begin
    eff_len = clamp_len(delay_len);

    // Stage 1: the sample in stage 2 has not yet bumped its channel's pointer
    // and fill; if it belongs to the same channel, account for it here so
    // back-to-back samples see the slot they will actually be written to.
    pending  = vld_p1_q && (ch_p1_q == io.in_ch);
    cur_ptr  = wr_ptr_q[io.in_ch] + AW'(pending);
    cur_fill = fill_q[io.in_ch];
    if (pending && (cur_fill != FILL_MAX))
      cur_fill = cur_fill + 1'b1;
    rd_addr = {io.in_ch, cur_ptr - eff_len};

    vld_p1_d      = io.in_valid;
    ch_p1_d       = ch_p1_q;
    wptr_p1_d     = wptr_p1_q;
    data_p1_d     = data_p1_q;
    bypass_p1_d   = bypass_p1_q;
    shift_p1_d    = shift_p1_q;
    use_echo_p1_d = use_echo_p1_q;
    if (io.in_valid) begin
      ch_p1_d       = io.in_ch;
      wptr_p1_d     = cur_ptr;
      data_p1_d     = io.data_in;
      bypass_p1_d   = bypass;
      shift_p1_d    = gain_shift;
      use_echo_p1_d = (cur_fill >= eff_len);
    end

    // Stage 2: subtract the attenuated echo, saturate, write back.
    echo = '0;
    if (use_echo_p1_q)
      echo = rd_data_p1_q >>> shift_p1_q;
    diff   = (DATA_WIDTH+1)'(data_p1_q) - (DATA_WIDTH+1)'(echo);
    result = bypass_p1_q ? data_p1_q : sat(diff);

    out_valid_d = vld_p1_q;
    out_ch_d    = out_ch_q;
    data_out_d  = data_out_q;
    wr_ptr_d    = wr_ptr_q;
    fill_d      = fill_q;
    if (vld_p1_q) begin
      out_ch_d            = ch_p1_q;
      data_out_d          = result;
      wr_ptr_d[ch_p1_q]   = wr_ptr_q[ch_p1_q] + 1'b1;
      fill_d[ch_p1_q]     = (fill_q[ch_p1_q] == FILL_MAX) ? FILL_MAX : fill_q[ch_p1_q] + 1'b1;
    end
  end

  always_ff @(posedge sck or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      data_out_q  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
      end
    end else begin
      vld_p1_q    <= vld_p1_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      data_out_q  <= data_out_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
    end
  end

  always_ff @(posedge sck) begin
    ch_p1_q       <= ch_p1_d;
    wptr_p1_q     <= wptr_p1_d;
    data_p1_q     <= data_p1_d;
    bypass_p1_q   <= bypass_p1_d;
    shift_p1_q    <= shift_p1_d;
    use_echo_p1_q <= use_echo_p1_d;
  end

  // Delay-line RAM: synchronous read in stage 1, write-back from stage 2.
  // RAM is never cleared; fill gating hides stale words after reset.
  always_ff @(posedge sck) begin
    if (io.in_valid)
      rd_data_p1_q <= mem[rd_addr];
    if (vld_p1_q)
      mem[{ch_p1_q, wptr_p1_q}] <= result;
  end

  always_comb begin
    primed = '0;
    for (int c = 0; c < CHANNELS; c++)
      primed[c] = (fill_q[c] >= eff_len);
  end

  assign io.out_valid = out_valid_q;
  assign io.out_ch    = out_ch_q;
  assign io.data_out  = data_out_q;

endmodule
